// File: rtl/vga_pkg.sv
// Types and constants shared by the VGA pixel pipeline and the sync/position generator.
package vga_pkg;

  localparam int RGB_W     = 12;
  localparam int H_VIS_DEF = 640;
  localparam int V_VIS_DEF = 480;

  typedef enum logic [1:0] {
    RIGHT_DOWN = 2'b00,
    RIGHT_UP   = 2'b01,
    LEFT_DOWN  = 2'b10,
    LEFT_UP    = 2'b11
  } dir_t;

endpackage

// File: rtl/vga_sprite_motion.sv
// Sprite position and bounce-direction state, updated once per frame after the last visible pixel.
module vga_sprite_motion
  import vga_pkg::*;
#(
  parameter int H_VIS    = H_VIS_DEF,
  parameter int V_VIS    = V_VIS_DEF,
  parameter int SPR_SIZE = 32,
  parameter int STEP     = 2,
  parameter int X0       = 100,
  parameter int Y0       = 60
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        p_clk,
  input  logic        freeze,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [11:0] spr_x,
  output logic [11:0] spr_y
);

  dir_t        state_reg, state_next;
  logic [11:0] spr_x_reg, spr_x_next;
  logic [11:0] spr_y_reg, spr_y_next;
  logic        frame_tick;
  logic        x_left, y_up, x_left_next, y_up_next;
  logic [12:0] nx, ny;

  assign frame_tick = p_clk && (xpos == 12'(H_VIS - 1)) && (ypos == 12'(V_VIS - 1));
  assign nx = {1'b0, spr_x_reg} + 13'(STEP);
  assign ny = {1'b0, spr_y_reg} + 13'(STEP);

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= RIGHT_DOWN;
      spr_x_reg <= 12'(X0);
      spr_y_reg <= 12'(Y0);
    end else if (p_clk) begin
      state_reg <= state_next;
      spr_x_reg <= spr_x_next;
      spr_y_reg <= spr_y_next;
    end
  end

  always_comb begin
    x_left      = (state_reg == LEFT_DOWN) || (state_reg == LEFT_UP);
    y_up        = (state_reg == RIGHT_UP) || (state_reg == LEFT_UP);
    x_left_next = x_left;
    y_up_next   = y_up;
    spr_x_next  = spr_x_reg;
    spr_y_next  = spr_y_reg;
    state_next  = state_reg;
    if (frame_tick && !freeze) begin
      // Each axis bounces independently; a corner flips both on the same tick.
      if (!x_left) begin
        if (nx >= 13'(H_VIS - SPR_SIZE)) begin
          spr_x_next  = 12'(H_VIS - SPR_SIZE);
          x_left_next = 1'b1;
        end else begin
          spr_x_next = nx[11:0];
        end
      end else if (spr_x_reg <= 12'(STEP)) begin
        spr_x_next  = '0;
        x_left_next = 1'b0;
      end else begin
        spr_x_next = spr_x_reg - 12'(STEP);
      end

      if (!y_up) begin
        if (ny >= 13'(V_VIS - SPR_SIZE)) begin
          spr_y_next = 12'(V_VIS - SPR_SIZE);
          y_up_next  = 1'b1;
        end else begin
          spr_y_next = ny[11:0];
        end
      end else if (spr_y_reg <= 12'(STEP)) begin
        spr_y_next = '0;
        y_up_next  = 1'b0;
      end else begin
        spr_y_next = spr_y_reg - 12'(STEP);
      end

      case ({x_left_next, y_up_next})
        2'b00:   state_next = RIGHT_DOWN;
        2'b01:   state_next = RIGHT_UP;
        2'b10:   state_next = LEFT_DOWN;
        default: state_next = LEFT_UP;
      endcase
    end
  end

  assign spr_x = spr_x_reg;
  assign spr_y = spr_y_reg;

endmodule

// File: rtl/vga_sprite_gen.sv
// Two-stage pixel pipeline drawing a bouncing square sprite, with sync/active re-timed to match.
// Optional build macro VGA_SPRITE_BORDER_EN adds a white one-pixel frame around the visible area.
module vga_sprite_gen
  import vga_pkg::*;
#(
  parameter int               H_VIS      = H_VIS_DEF,
  parameter int               V_VIS      = V_VIS_DEF,
  parameter int               SPR_SIZE   = 32,
  parameter int               STEP       = 2,
  parameter int               X0         = 100,
  parameter int               Y0         = 60,
  parameter logic [RGB_W-1:0] SPR_COLOUR = 12'hF00,
  parameter logic [RGB_W-1:0] BG_COLOUR  = 12'h000,
  parameter logic             SYNC_IDLE  = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        P_CLK,
  input  logic        FREEZE,
  input  logic [11:0] XPOS,
  input  logic [11:0] YPOS,
  input  logic        HSYNC_IN,
  input  logic        VSYNC_IN,
  input  logic        DISP_ACTIVE_IN,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DISP_ACTIVE,
  output logic [3:0]  Ro,
  output logic [3:0]  Go,
  output logic [3:0]  Bo
);

  logic [11:0]      spr_x, spr_y;
  logic [12:0]      x13, y13, sx13, sy13;
  logic             hit;
  logic             hit_s1_reg, active_s1_reg, hsync_s1_reg, vsync_s1_reg;
  logic             hsync_reg, vsync_reg, active_reg;
  logic [RGB_W-1:0] rgb_reg, rgb_next;

  vga_sprite_motion #(
    .H_VIS    (H_VIS),
    .V_VIS    (V_VIS),
    .SPR_SIZE (SPR_SIZE),
    .STEP     (STEP),
    .X0       (X0),
    .Y0       (Y0)
  ) u_motion (
    .clk    (CLK),
    .srst   (RST),
    .p_clk  (P_CLK),
    .freeze (FREEZE),
    .xpos   (XPOS),
    .ypos   (YPOS),
    .spr_x  (spr_x),
    .spr_y  (spr_y)
  );

  // Widened so spr + SPR_SIZE cannot wrap near the top of the 12-bit range.
  assign x13  = {1'b0, XPOS};
  assign y13  = {1'b0, YPOS};
  assign sx13 = {1'b0, spr_x};
  assign sy13 = {1'b0, spr_y};
  assign hit  = (x13 >= sx13) && (x13 < sx13 + 13'(SPR_SIZE)) &&
                (y13 >= sy13) && (y13 < sy13 + 13'(SPR_SIZE));

`ifdef VGA_SPRITE_BORDER_EN
  logic border_s1_reg;
  always_ff @(posedge CLK) begin
    if (RST) begin
      border_s1_reg <= 1'b0;
    end else if (P_CLK) begin
      border_s1_reg <= (XPOS == 12'd0) || (XPOS == 12'(H_VIS - 1)) ||
                       (YPOS == 12'd0) || (YPOS == 12'(V_VIS - 1));
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_s1_reg    <= 1'b0;
      active_s1_reg <= 1'b0;
      hsync_s1_reg  <= SYNC_IDLE;
      vsync_s1_reg  <= SYNC_IDLE;
      rgb_reg       <= '0;
      active_reg    <= 1'b0;
      hsync_reg     <= SYNC_IDLE;
      vsync_reg     <= SYNC_IDLE;
    end else if (P_CLK) begin
      hit_s1_reg    <= hit;
      active_s1_reg <= DISP_ACTIVE_IN;
      hsync_s1_reg  <= HSYNC_IN;
      vsync_s1_reg  <= VSYNC_IN;
      rgb_reg       <= rgb_next;
      active_reg    <= active_s1_reg;
      hsync_reg     <= hsync_s1_reg;
      vsync_reg     <= vsync_s1_reg;
    end
  end

  always_comb begin
    rgb_next = '0;
    if (active_s1_reg) begin
`ifdef VGA_SPRITE_BORDER_EN
      if (border_s1_reg)   rgb_next = 12'hFFF;
      else if (hit_s1_reg) rgb_next = SPR_COLOUR;
      else                 rgb_next = BG_COLOUR;
`else
      if (hit_s1_reg) rgb_next = SPR_COLOUR;
      else            rgb_next = BG_COLOUR;
`endif
    end
  end

  assign {Ro, Go, Bo} = rgb_reg;
  assign HSYNC        = hsync_reg;
  assign VSYNC        = vsync_reg;
  assign DISP_ACTIVE  = active_reg;

endmodule

// File: tb/tb_vga_sprite_gen.sv
// Randomized bench: four sprite generators with different start positions checked against a bounce model.
module tb_vga_sprite_gen;

  localparam int N     = 4;
  localparam int H_VIS = 640;
  localparam int V_VIS = 480;
  localparam int SPR   = 32;
  localparam int STEP  = 2;
  localparam logic [14:0] RESET_VAL = {1'b1, 1'b1, 1'b0, 12'h000};

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        P_CLK = 1'b0;
  logic        FREEZE = 1'b0;
  logic [11:0] XPOS = '0;
  logic [11:0] YPOS = '0;
  logic        HSYNC_IN = 1'b1;
  logic        VSYNC_IN = 1'b1;
  logic        DISP_ACTIVE_IN = 1'b0;

  logic       hs_w[N], vs_w[N], act_w[N];
  logic [3:0] r_w[N], g_w[N], b_w[N];

  int          x0_tab[N] = '{100, 600, 606, 0};
  int          y0_tab[N] = '{60, 60, 446, 0};
  int          mx[N], my[N], mdx[N], mdy[N];
  logic [14:0] exp_s1[N], exp_out[N];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 CLK = ~CLK;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      vga_sprite_gen #(
        .X0 (gi == 0 ? 100 : gi == 1 ? 600 : gi == 2 ? 606 : 0),
        .Y0 (gi == 0 ? 60  : gi == 1 ? 60  : gi == 2 ? 446 : 0)
      ) u_dut (
        .CLK            (CLK),
        .RST            (RST),
        .P_CLK          (P_CLK),
        .FREEZE         (FREEZE),
        .XPOS           (XPOS),
        .YPOS           (YPOS),
        .HSYNC_IN       (HSYNC_IN),
        .VSYNC_IN       (VSYNC_IN),
        .DISP_ACTIVE_IN (DISP_ACTIVE_IN),
        .HSYNC          (hs_w[gi]),
        .VSYNC          (vs_w[gi]),
        .DISP_ACTIVE    (act_w[gi]),
        .Ro             (r_w[gi]),
        .Go             (g_w[gi]),
        .Bo             (b_w[gi])
      );
    end
  endgenerate

  task automatic check_val(input string tag, input logic [14:0] obs, input logic [14:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got {hs,vs,act,rgb}=%h expected %h at t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++)
      check_val($sformatf("%s_dut%0d", tag, i),
                {hs_w[i], vs_w[i], act_w[i], r_w[i], g_w[i], b_w[i]}, exp_out[i]);
  endtask

  function automatic logic [14:0] pix_exp(int i, int x, int y, bit act, bit hs, bit vs);
    logic [11:0] rgb;
    bit          in_spr;
    in_spr = (x >= mx[i]) && (x < mx[i] + SPR) && (y >= my[i]) && (y < my[i] + SPR);
    rgb = 12'h000;
    if (act) begin
      rgb = in_spr ? 12'hF00 : 12'h000;
`ifdef VGA_SPRITE_BORDER_EN
      if (x == 0 || x == H_VIS - 1 || y == 0 || y == V_VIS - 1) rgb = 12'hFFF;
`endif
    end
    return {hs, vs, act, rgb};
  endfunction

  // Bounce rule for one frame: advance, clamp at the wall and reverse.
  task automatic model_move(input int i);
    if (mdx[i] > 0) begin
      if (mx[i] + STEP >= H_VIS - SPR) begin mx[i] = H_VIS - SPR; mdx[i] = -1; end
      else mx[i] += STEP;
    end else begin
      if (mx[i] <= STEP) begin mx[i] = 0; mdx[i] = 1; end
      else mx[i] -= STEP;
    end
    if (mdy[i] > 0) begin
      if (my[i] + STEP >= V_VIS - SPR) begin my[i] = V_VIS - SPR; mdy[i] = -1; end
      else my[i] += STEP;
    end else begin
      if (my[i] <= STEP) begin my[i] = 0; mdy[i] = 1; end
      else my[i] -= STEP;
    end
  endtask

  task automatic do_reset(input int cycles);
    RST = 1'b1;
    repeat (cycles) begin
      P_CLK = 1'($urandom_range(0, 1));
      XPOS = 12'($urandom_range(0, 4095));
      YPOS = 12'($urandom_range(0, 4095));
      HSYNC_IN = 1'($urandom_range(0, 1));
      VSYNC_IN = 1'($urandom_range(0, 1));
      DISP_ACTIVE_IN = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      for (int i = 0; i < N; i++) begin
        exp_s1[i] = RESET_VAL; exp_out[i] = RESET_VAL;
        mx[i] = x0_tab[i]; my[i] = y0_tab[i]; mdx[i] = 1; mdy[i] = 1;
      end
      check_all("reset");
    end
    RST = 1'b0;
    P_CLK = 1'b0;
  endtask

  // One pixel strobe, then `gap` idle clocks with garbage inputs that must not disturb anything.
  task automatic strobe(input int x, input int y, input bit act, input bit hs, input bit vs,
                        input bit frz, input int gap);
    int  xi, yi;
    bit  tick;
    XPOS = 12'(x); YPOS = 12'(y);
    DISP_ACTIVE_IN = act; HSYNC_IN = hs; VSYNC_IN = vs; FREEZE = frz;
    P_CLK = 1'b1;
    xi = int'(XPOS); yi = int'(YPOS);
    tick = (xi == H_VIS - 1) && (yi == V_VIS - 1);
    for (int i = 0; i < N; i++) begin
      exp_out[i] = exp_s1[i];
      exp_s1[i] = pix_exp(i, xi, yi, act, hs, vs);
      if (tick && !frz) model_move(i);
    end
    @(posedge CLK); #1;
    P_CLK = 1'b0;
    check_all(tick ? "tick" : "pix");
    repeat (gap) begin
      XPOS = 12'($urandom_range(0, 4095)); YPOS = 12'($urandom_range(0, 4095));
      HSYNC_IN = 1'($urandom_range(0, 1)); VSYNC_IN = 1'($urandom_range(0, 1));
      DISP_ACTIVE_IN = 1'($urandom_range(0, 1)); FREEZE = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
      check_all("hold");
    end
  endtask

  task automatic rand_pixel();
    int x, y;
    x = (($urandom_range(0, 15)) == 0) ? 4095 - $urandom_range(0, 40) : $urandom_range(0, 799);
    y = $urandom_range(0, 524);
    strobe(x, y, (x < H_VIS && y < V_VIS) ? 1'b1 : 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 2));
  endtask

  task automatic probe_sprite(input int i);
    int sx, sy;
    sx = mx[i]; sy = my[i];
    strobe(sx, sy, 1'b1, 1'b1, 1'b1, 1'b0, $urandom_range(0, 1));
    strobe(sx - 1, sy, 1'b1, 1'b0, 1'b1, 1'b0, $urandom_range(0, 1));
    strobe(sx + SPR - 1, sy + SPR - 1, 1'b1, 1'b1, 1'b0, 1'b0, $urandom_range(0, 1));
    strobe(sx + SPR, sy + SPR - 1, 1'b1, 1'b1, 1'b1, 1'b0, $urandom_range(0, 1));
    strobe(sx + SPR - 1, sy + SPR, 1'b1, 1'b0, 1'b0, 1'b0, $urandom_range(0, 1));
    strobe(sx, sy - 1, 1'b1, 1'b1, 1'b1, 1'b0, $urandom_range(0, 1));
  endtask

  initial begin
    do_reset(3);

    // Directed pixels from the default start position, plus the border corner.
    strobe(100, 60, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    strobe(99, 60, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    strobe(132, 60, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    strobe(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    strobe(100, 60, 1'b0, 1'b1, 1'b1, 1'b0, 1);
    strobe(0, 60, 1'b1, 1'b1, 1'b1, 1'b0, 1);

    // Sync pulse with one strobe every fourth clock.
    for (int k = 0; k < 12; k++)
      strobe(700 + k, 490, 1'b0, (k >= 3 && k < 6) ? 1'b0 : 1'b1, (k == 8) ? 1'b0 : 1'b1, 1'b0, 3);

    // Frames: random pixels, sprite probes, then the frame tick (frozen for three of them).
    for (int f = 0; f < 12; f++) begin
      repeat (15) rand_pixel();
      for (int i = 0; i < N; i++) probe_sprite(i);
      strobe(H_VIS - 1, V_VIS - 1, 1'b1, 1'b1, 1'b1, (f >= 5 && f <= 7) ? 1'b1 : 1'b0,
             $urandom_range(0, 2));
    end
    for (int i = 0; i < N; i++) probe_sprite(i);

    // Reset in the middle of a line, then confirm the restart position.
    strobe(299, 100, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    XPOS = 12'd300; YPOS = 12'd100; DISP_ACTIVE_IN = 1'b1; HSYNC_IN = 1'b0; VSYNC_IN = 1'b0;
    do_reset(1);
    strobe(101, 61, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    strobe(99, 61, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < N; i++) probe_sprite(i);
    strobe(H_VIS - 1, V_VIS - 1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < N; i++) probe_sprite(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
